// File: rtl/depkt_pkg.sv
// rtl/depkt_pkg.sv - shared types and packet field offsets for the PE depacketizer
package depkt_pkg;

  typedef enum logic {
    PKT_FILT = 1'b0,
    PKT_PIX  = 1'b1
  } pkt_type_e;

  localparam int DROP_CNT_W = 8;

  // Packet layout, MSB to LSB: type, dst[ADDRW], src[ADDRW], payload[NPIX*DWIDTH]
  function automatic int payload_w(input int npix, input int dwidth);
    return npix * dwidth;
  endfunction

  function automatic int src_lsb(input int npix, input int dwidth);
    return npix * dwidth;
  endfunction

  function automatic int dst_lsb(input int addrw, input int npix, input int dwidth);
    return addrw + npix * dwidth;
  endfunction

  function automatic int type_bit(input int addrw, input int npix, input int dwidth);
    return 2 * addrw + npix * dwidth;
  endfunction

  function automatic int pkt_width(input int addrw, input int npix, input int dwidth);
    return 1 + 2 * addrw + npix * dwidth;
  endfunction

endpackage

// File: rtl/depkt_fifo.sv
// rtl/depkt_fifo.sv - synchronous FIFO with registered storage and full/empty flags
module depkt_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;

  logic w_do_push;
  logic w_do_pop;

  // A full FIFO refuses a push even when it pops in the same cycle
  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  // Head is read straight from storage; contents are don't-care while empty
  assign o_dout = r_mem[r_rptr];

  // Pointer and occupancy update; DEPTH is a power of two so pointers wrap naturally
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + AW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage write; no reset needed since occupancy gates visibility
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_din;
  end

endmodule

// File: rtl/pe_depacketizer_fifo.sv
// rtl/pe_depacketizer_fifo.sv - PE depacketizer splitting NoC packets into pixel/filter FIFOs; option macro DEPKT_ADDR_CHECK_EN
module pe_depacketizer_fifo
  import depkt_pkg::*;
#(
  parameter int DWIDTH  = 8,
  parameter int ADDRW   = 3,
  parameter int NPIX    = 5,
  parameter int NFILT   = 3,
  parameter int DEPTH   = 4,
  parameter int MY_ADDR = 0,
  localparam int PWIDTH = pkt_width(ADDRW, NPIX, DWIDTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [PWIDTH-1:0]       in_pkt,
  output logic                    pix_valid,
  input  logic                    pix_ready,
  output logic [NPIX*DWIDTH-1:0]  pix_data,
  output logic [ADDRW-1:0]        pix_src,
  output logic                    filt_valid,
  input  logic                    filt_ready,
  output logic [NFILT*DWIDTH-1:0] filt_data,
  output logic [ADDRW-1:0]        filt_src,
  output logic [DROP_CNT_W-1:0]   drop_cnt
);

  localparam int TYPE_BIT = type_bit(ADDRW, NPIX, DWIDTH);
  localparam int DST_LSB  = dst_lsb(ADDRW, NPIX, DWIDTH);
  localparam int SRC_LSB  = src_lsb(NPIX, DWIDTH);
  localparam int PIX_PW   = payload_w(NPIX, DWIDTH);
  localparam int FILT_PW  = payload_w(NFILT, DWIDTH);
  localparam int PIX_W    = ADDRW + PIX_PW;
  localparam int FILT_W   = ADDRW + FILT_PW;

  logic              w_is_pix;
  logic [ADDRW-1:0]  w_dst;
  logic [ADDRW-1:0]  w_src;
  logic              w_accept;
  logic              w_deliver;
  logic              w_pix_push;
  logic              w_filt_push;
  logic              w_pix_full;
  logic              w_pix_empty;
  logic              w_filt_full;
  logic              w_filt_empty;
  logic [PIX_W-1:0]  w_pix_dout;
  logic [FILT_W-1:0] w_filt_dout;

  assign w_is_pix = (pkt_type_e'(in_pkt[TYPE_BIT]) == PKT_PIX);
  assign w_dst    = in_pkt[DST_LSB +: ADDRW];
  assign w_src    = in_pkt[SRC_LSB +: ADDRW];

  // Readiness depends only on the FIFO the packet targets, so one full stream never stalls the other
  assign in_ready = w_is_pix ? ~w_pix_full : ~w_filt_full;
  assign w_accept = in_valid & in_ready;

`ifdef DEPKT_ADDR_CHECK_EN
  logic [DROP_CNT_W-1:0] r_drop_cnt;

  // Misaddressed packets are consumed but not stored
  assign w_deliver = (w_dst == ADDRW'(MY_ADDR));
  assign drop_cnt  = r_drop_cnt;

  // Saturating count of accepted-but-discarded packets
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_drop_cnt <= '0;
    end else if (w_accept && !w_deliver && (r_drop_cnt != '1)) begin
      r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
    end
  end
`else
  logic [ADDRW-1:0] w_unused_addr;

  // Destination is ignored: every accepted packet is delivered
  assign w_deliver     = 1'b1;
  assign drop_cnt      = '0;
  assign w_unused_addr = w_dst ^ ADDRW'(MY_ADDR);
`endif

  assign w_pix_push  = w_accept & w_is_pix & w_deliver;
  assign w_filt_push = w_accept & ~w_is_pix & w_deliver;

  depkt_fifo #(
    .WIDTH (PIX_W),
    .DEPTH (DEPTH)
  ) u_pix_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_pix_push),
    .i_din   ({w_src, in_pkt[PIX_PW-1:0]}),
    .i_pop   (pix_ready),
    .o_dout  (w_pix_dout),
    .o_full  (w_pix_full),
    .o_empty (w_pix_empty)
  );

  depkt_fifo #(
    .WIDTH (FILT_W),
    .DEPTH (DEPTH)
  ) u_filt_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_filt_push),
    .i_din   ({w_src, in_pkt[FILT_PW-1:0]}),
    .i_pop   (filt_ready),
    .o_dout  (w_filt_dout),
    .o_full  (w_filt_full),
    .o_empty (w_filt_empty)
  );

  assign pix_valid  = ~w_pix_empty;
  assign pix_data   = w_pix_dout[PIX_PW-1:0];
  assign pix_src    = w_pix_dout[PIX_W-1 -: ADDRW];
  assign filt_valid = ~w_filt_empty;
  assign filt_data  = w_filt_dout[FILT_PW-1:0];
  assign filt_src   = w_filt_dout[FILT_W-1 -: ADDRW];

endmodule

// File: tb/tb_pe_depacketizer_fifo.sv
// tb/tb_pe_depacketizer_fifo.sv - self-checking bench for pe_depacketizer_fifo
module tb_pe_depacketizer_fifo;

  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int NPIX  = 5;
  localparam int NFILT = 3;
  localparam int DEPTH = 4;
  localparam int MYA   = 2;
  localparam int PW    = 1 + 2*AW + NPIX*DW;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [PW-1:0]       in_pkt = '0;
  logic                pix_valid;
  logic                pix_ready = 1'b0;
  logic [NPIX*DW-1:0]  pix_data;
  logic [AW-1:0]       pix_src;
  logic                filt_valid;
  logic                filt_ready = 1'b0;
  logic [NFILT*DW-1:0] filt_data;
  logic [AW-1:0]       filt_src;
  logic [7:0]          drop_cnt;

  pe_depacketizer_fifo #(
    .DWIDTH (DW), .ADDRW (AW), .NPIX (NPIX), .NFILT (NFILT), .DEPTH (DEPTH), .MY_ADDR (MYA)
  ) dut (
    .clk (clk), .rst_n (rst_n),
    .in_valid (in_valid), .in_ready (in_ready), .in_pkt (in_pkt),
    .pix_valid (pix_valid), .pix_ready (pix_ready), .pix_data (pix_data), .pix_src (pix_src),
    .filt_valid (filt_valid), .filt_ready (filt_ready), .filt_data (filt_data), .filt_src (filt_src),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0]      src;
    logic [NPIX*DW-1:0] data;
  } exp_t;

  typedef struct {
    bit                 typ;
    logic [AW-1:0]      src;
    logic [NPIX*DW-1:0] pl;
    bit                 exp_ready;
  } vec_t;

  exp_t pix_q[$];
  exp_t filt_q[$];
  exp_t mon_p;
  exp_t mon_f;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic bit exp_deliver(input logic [AW-1:0] dst);
`ifdef DEPKT_ADDR_CHECK_EN
    return dst == AW'(MYA);
`else
    return 1'b1;
`endif
  endfunction

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present a packet, wait (bounded) for in_ready, log the expected output, complete the handshake
  task automatic send(input bit typ, input logic [AW-1:0] dst, input logic [AW-1:0] src,
                      input logic [NPIX*DW-1:0] pl);
    int n = 0;
    in_pkt   = {typ, dst, src, pl};
    in_valid = 1'b1;
    #1;
    while (!in_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 200) begin
      total_cnt++;
      $display("FAIL send_timeout: in_ready stuck at 0, required 1");
    end else begin
      if (exp_deliver(dst)) begin
        if (typ) pix_q.push_back(exp_t'{src, pl});
        else     filt_q.push_back(exp_t'{src, pl});
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  // Output monitor: a handshake that will complete at the next rising edge pops the scoreboard
  always @(negedge clk) begin
    if (rst_n && pix_valid && pix_ready) begin
      if (pix_q.size() == 0) begin
        total_cnt++;
        $display("FAIL pix_unexpected: got word %0h, required none", pix_data);
      end else begin
        mon_p = pix_q.pop_front();
        chk("pix_data", 64'(pix_data), 64'(mon_p.data));
        chk("pix_src", 64'(pix_src), 64'(mon_p.src));
      end
    end
    if (rst_n && filt_valid && filt_ready) begin
      if (filt_q.size() == 0) begin
        total_cnt++;
        $display("FAIL filt_unexpected: got word %0h, required none", filt_data);
      end else begin
        mon_f = filt_q.pop_front();
        chk("filt_data", 64'(filt_data), 64'(mon_f.data[NFILT*DW-1:0]));
        chk("filt_src", 64'(filt_src), 64'(mon_f.src));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t vecs[4];
  logic [NPIX*DW-1:0] pl;

  initial begin
    vecs[0] = '{1'b1, 3'd1, {8'd1, 8'd2, 8'd3, 8'd4, 8'd5}, 1'b1};
    vecs[1] = '{1'b0, 3'd4, {8'd0, 8'd0, 8'd11, 8'd12, 8'd13}, 1'b1};
    vecs[2] = '{1'b1, 3'd6, {8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5}, 1'b1};
    vecs[3] = '{1'b0, 3'd7, {8'hFF, 8'hEE, 8'h21, 8'h22, 8'h23}, 1'b1};

    // Reset state
    step(2);
    rst_n = 1'b1;
    chk("reset_pix_valid", 64'(pix_valid), 64'd0);
    chk("reset_filt_valid", 64'(filt_valid), 64'd0);
    chk("reset_drop_cnt", 64'(drop_cnt), 64'd0);

    // 1: single pixel packet, visible one cycle after acceptance
    send(1'b1, 3'd2, 3'd3, {8'd10, 8'd20, 8'd30, 8'd40, 8'd50});
    chk("t1_pix_valid", 64'(pix_valid), 64'd1);
    chk("t1_pix_data", 64'(pix_data), 64'h0A141E2832);
    chk("t1_pix_src", 64'(pix_src), 64'd3);
    chk("t1_filt_valid", 64'(filt_valid), 64'd0);
    pix_ready = 1'b1;
    step(2);
    chk("t1_drained", 64'(pix_valid), 64'd0);

    // 2: fill the filter FIFO, pixel path still open, no same-cycle bypass on full
    filt_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      send(1'b0, 3'd2, 3'(i), {16'd0, 8'(i + 100), 8'(i + 110), 8'(i + 120)});
    in_pkt   = {1'b0, 3'd2, 3'd5, {16'd0, 8'd77, 8'd78, 8'd79}};
    in_valid = 1'b1;
    #1;
    chk("t2_filt_full_ready", 64'(in_ready), 64'd0);
    in_pkt = {1'b1, 3'd2, 3'd6, {8'd60, 8'd61, 8'd62, 8'd63, 8'd64}};
    #1;
    chk("t2_pix_ready_while_filt_full", 64'(in_ready), 64'd1);
    send(1'b1, 3'd2, 3'd6, {8'd60, 8'd61, 8'd62, 8'd63, 8'd64});
    filt_ready = 1'b1;
    in_pkt     = {1'b0, 3'd2, 3'd5, {16'd0, 8'd77, 8'd78, 8'd79}};
    in_valid   = 1'b1;
    #1;
    chk("t2_no_bypass", 64'(in_ready), 64'd0);
    send(1'b0, 3'd2, 3'd5, {16'd0, 8'd77, 8'd78, 8'd79});
    step(8);
    chk("t2_filt_drained", 64'(filt_valid), 64'd0);
    chk("t2_filt_q_empty", 64'(filt_q.size()), 64'd0);

    // 3: mixed stream from the vector table, both consumers ready
    pix_ready  = 1'b1;
    filt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_pkt   = {vecs[i].typ, 3'd2, vecs[i].src, vecs[i].pl};
      in_valid = 1'b1;
      #1;
      chk("t3_in_ready", 64'(in_ready), 64'(vecs[i].exp_ready));
      send(vecs[i].typ, 3'd2, vecs[i].src, vecs[i].pl);
      chk("t3_latency", 64'(vecs[i].typ ? pix_valid : filt_valid), 64'd1);
    end
    step(3);
    chk("t3_no_loss", 64'(pix_q.size() + filt_q.size()), 64'd0);

    // 4: steady push+pop at occupancy 2, across 3*DEPTH words for pointer wrap
    pix_ready = 1'b0;
    for (int i = 0; i < 3*DEPTH; i++) begin
      pl = {8'(i), 8'(i + 1), 8'(i + 2), 8'(i + 3), 8'(i + 4)};
      if (i == 2) pix_ready = 1'b1;
      send(1'b1, 3'd2, 3'(i), pl);
      if (i >= 2) chk("t4_count_hold", 64'(dut.u_pix_fifo.r_count), 64'd2);
    end
    step(4);
    chk("t4_drained", 64'(pix_valid), 64'd0);

    // 5: reset with three words buffered
    pix_ready  = 1'b0;
    filt_ready = 1'b0;
    send(1'b1, 3'd2, 3'd1, 40'h1111111111);
    send(1'b1, 3'd2, 3'd2, 40'h2222222222);
    send(1'b0, 3'd2, 3'd3, 40'h0000333333);
    rst_n = 1'b0;
    step(1);
    chk("t5_pix_valid", 64'(pix_valid), 64'd0);
    chk("t5_filt_valid", 64'(filt_valid), 64'd0);
    chk("t5_drop_cnt", 64'(drop_cnt), 64'd0);
    rst_n = 1'b1;
    pix_q.delete();
    filt_q.delete();
    pix_ready  = 1'b1;
    filt_ready = 1'b1;
    send(1'b1, 3'd2, 3'd4, 40'h4455667788);
    chk("t5_after_reset_valid", 64'(pix_valid), 64'd1);
    step(2);

    // 6: destination filtering
`ifdef DEPKT_ADDR_CHECK_EN
    send(1'b1, 3'd5, 3'd1, 40'hDEADBEEF01);
    step(2);
    chk("t6_drop_no_output", 64'(pix_valid), 64'd0);
    chk("t6_drop_cnt1", 64'(drop_cnt), 64'd1);
    send(1'b1, 3'd2, 3'd1, 40'h0102030405);
    chk("t6_match_delivered", 64'(pix_valid), 64'd1);
    step(2);
    filt_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) send(1'b0, 3'd2, 3'd0, 40'(i + 1));
    in_pkt   = {1'b0, 3'd5, 3'd0, 40'h0};
    in_valid = 1'b1;
    #1;
    chk("t6_full_refused", 64'(in_ready), 64'd0);
    step(1);
    in_valid = 1'b0;
    chk("t6_refused_not_dropped", 64'(drop_cnt), 64'd1);
    filt_ready = 1'b1;
    step(6);
    for (int i = 0; i < 259; i++) send(i[0], 3'd5, 3'd0, 40'(i));
    step(1);
    chk("t6_drop_saturate", 64'(drop_cnt), 64'd255);
`else
    send(1'b1, 3'd5, 3'd1, 40'hDEADBEEF01);
    chk("t6_dst_ignored", 64'(pix_valid), 64'd1);
    step(2);
    chk("t6_drop_tied0", 64'(drop_cnt), 64'd0);
`endif

    step(5);
    chk("end_pix_q_empty", 64'(pix_q.size()), 64'd0);
    chk("end_filt_q_empty", 64'(filt_q.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
